// File: rtl/data_mem_sync_if.sv
// Request/response bus of the synchronous data memory.
// The CPU side uses master, the memory uses slave.
interface data_mem_sync_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);
   logic                  Mem_Req;
   logic                  Mem_Write;
   logic [ADDR_W-1:0]     Mem_Addr;
   logic [DATA_W-1:0]     M_W_Data;
   logic [DATA_W/8-1:0]   M_BE;
   logic                  Mem_Ready;
   logic [DATA_W-1:0]     M_R_Data;
   logic                  M_R_Valid;
   logic                  Mem_Err;

   modport master (
      output Mem_Req, Mem_Write, Mem_Addr, M_W_Data, M_BE,
      input  Mem_Ready, M_R_Data, M_R_Valid, Mem_Err
   );

   modport slave (
      input  Mem_Req, Mem_Write, Mem_Addr, M_W_Data, M_BE,
      output Mem_Ready, M_R_Data, M_R_Valid, Mem_Err
   );
endinterface

// File: rtl/data_mem_sync.sv
// Synchronous word-addressed data memory: byte-lane RAMs, zero-clear after
// reset, pipelined reads with READ_LAT of 1 or 2, out-of-range error pulses.
module data_mem_sync_lane #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    q
);
   logic [7:0] ram [DEPTH];

   // No reset here so the lane maps onto a block RAM byte column.
   always_ff @(posedge clk) begin
      if (we) ram[addr] <= wdata;
      if (re) q <= ram[addr];
   end
endmodule

module data_mem_sync #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int READ_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_sync_if.slave  bus
);
   localparam int NB = DATA_W / 8;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state, state_n;
   logic [ADDR_W-1:0]   clr_cnt;
   logic                clearing, ready;
   logic                acc, rd_acc, wr_acc, in_range;
   logic [AW-1:0]       ram_addr;
   logic [NB-1:0]       lane_we;
   logic [NB-1:0][7:0]  lane_wd, lane_q;
   logic [READ_LAT:1]   vld_pipe, oor_pipe;
   logic                wr_err_q, zero_q;
   logic [DATA_W-1:0]   rd_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_n;
         if (clearing) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      if (state == CLEAR && clr_cnt == LAST) state_n = IDLE;
   end

   always_comb begin
      clearing = (state == CLEAR);
      ready    = (state == IDLE);
   end

   // Full-width compare: no aliasing of out-of-range addresses into the array.
   assign in_range = {1'b0, bus.Mem_Addr} < DEPTH_X;
   assign acc      = bus.Mem_Req & ready;
   assign rd_acc   = acc & ~bus.Mem_Write;
   assign wr_acc   = acc &  bus.Mem_Write;
   assign ram_addr = clearing ? clr_cnt[AW-1:0] : bus.Mem_Addr[AW-1:0];

   for (genvar i = 0; i < NB; i++) begin : g_lane
      assign lane_we[i] = clearing | (wr_acc & in_range & bus.M_BE[i]);
      assign lane_wd[i] = clearing ? 8'h00 : bus.M_W_Data[8*i +: 8];

      data_mem_sync_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
         .clk   (clk),
         .we    (lane_we[i]),
         .re    (rd_acc & in_range),
         .addr  (ram_addr),
         .wdata (lane_wd[i]),
         .q     (lane_q[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         oor_pipe <= '0;
         wr_err_q <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         vld_pipe[1] <= rd_acc;
         oor_pipe[1] <= rd_acc & ~in_range;
         for (int i = 2; i <= READ_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            oor_pipe[i] <= oor_pipe[i-1];
         end
         wr_err_q <= wr_acc & ~in_range;
         if (rd_acc) zero_q <= ~in_range;
      end
   end

   // zero_q masks the RAM output after reset and after an out-of-range read,
   // so the held read data stays correct without resetting the RAM register.
   assign rd_word = zero_q ? '0 : DATA_W'(lane_q);

   if (READ_LAT == 1) begin : g_lat1
      assign bus.M_R_Data = rd_word;
   end else begin : g_lat2
      logic [DATA_W-1:0] dout_r;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)           dout_r <= '0;
         else if (vld_pipe[1]) dout_r <= rd_word;
      end
      assign bus.M_R_Data = dout_r;
   end

   assign bus.Mem_Ready = ready;
   assign bus.M_R_Valid = vld_pipe[READ_LAT];
   assign bus.Mem_Err   = oor_pipe[READ_LAT] | wr_err_q;
endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: DUT 0 is DEPTH=16/READ_LAT=1, DUT 1 is DEPTH=200/READ_LAT=2.
// Expected responses are queued with their due cycle and checked every cycle.
module tb_data_mem_sync;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req [2];
   logic        wr  [2];
   logic [7:0]  addr[2];
   logic [31:0] wd  [2];
   logic [3:0]  be  [2];
   logic        rdy [2];
   logic        vld [2];
   logic        err [2];
   logic [31:0] rdata[2];

   data_mem_sync_if #(.DATA_W(32), .ADDR_W(8)) ifa ();
   data_mem_sync_if #(.DATA_W(32), .ADDR_W(8)) ifb ();

   data_mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(16), .READ_LAT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   data_mem_sync #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .READ_LAT(2)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   assign ifa.Mem_Req = req[0];  assign ifb.Mem_Req = req[1];
   assign ifa.Mem_Write = wr[0]; assign ifb.Mem_Write = wr[1];
   assign ifa.Mem_Addr = addr[0]; assign ifb.Mem_Addr = addr[1];
   assign ifa.M_W_Data = wd[0];  assign ifb.M_W_Data = wd[1];
   assign ifa.M_BE = be[0];      assign ifb.M_BE = be[1];
   assign rdy[0] = ifa.Mem_Ready; assign rdy[1] = ifb.Mem_Ready;
   assign vld[0] = ifa.M_R_Valid; assign vld[1] = ifb.M_R_Valid;
   assign err[0] = ifa.Mem_Err;   assign err[1] = ifb.Mem_Err;
   assign rdata[0] = ifa.M_R_Data; assign rdata[1] = ifb.M_R_Data;

   typedef struct {
      int        due;
      bit        rd;
      bit [31:0] data;
      bit        err;
   } exp_t;

   typedef struct {
      int        d;
      bit        w;
      bit [7:0]  a;
      bit [31:0] wdat;
      bit [3:0]  b;
      bit [31:0] exp;
      bit        eerr;
   } vec_t;

   exp_t sbq[2][$];
   vec_t vecs[$];
   int   total = 0;
   int   bad = 0;
   bit   mon_en = 1'b0;

   function automatic int lat(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, expv);
      end
   endtask

   // Per-cycle monitor: every response bit is compared against the scoreboard.
   bit        m_ev, m_ee;
   bit [31:0] m_ed;
   exp_t      m_e;
   always @(negedge clk) begin
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            m_ev = 1'b0; m_ee = 1'b0; m_ed = '0;
            while (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
               m_e = sbq[d].pop_front();
               if (m_e.due < cyc) chk($sformatf("late_entry%0d", d), 32'(m_e.due), 32'(cyc));
               if (m_e.rd) begin m_ev = 1'b1; m_ed = m_e.data; end
               m_ee = m_ee | m_e.err;
            end
            chk($sformatf("r_valid%0d", d), 32'(vld[d]), 32'(m_ev));
            chk($sformatf("mem_err%0d", d), 32'(err[d]), 32'(m_ee));
            if (m_ev) chk($sformatf("r_data%0d", d), rdata[d], m_ed);
         end
      end
   end

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wd[d] = '0; be[d] = '0;
      end
   endtask

   task automatic drive(vec_t v);
      exp_t e;
      @(negedge clk);
      idle_all();
      chk($sformatf("ready%0d", v.d), 32'(rdy[v.d]), 32'd1);
      req[v.d] = 1'b1; wr[v.d] = v.w; addr[v.d] = v.a; wd[v.d] = v.wdat; be[v.d] = v.b;
      e.due  = cyc + (v.w ? 1 : lat(v.d));
      e.rd   = !v.w;
      e.data = v.exp;
      e.err  = v.eerr;
      if (!v.w || v.eerr) sbq[v.d].push_back(e);
   endtask

   task automatic add(int d, bit w, bit [7:0] a, bit [31:0] wdat, bit [3:0] b,
                      bit [31:0] expv, bit eerr);
      vec_t v;
      v.d = d; v.w = w; v.a = a; v.wdat = wdat; v.b = b; v.exp = expv; v.eerr = eerr;
      vecs.push_back(v);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      idle_all();
      while ((sbq[0].size() > 0 || sbq[1].size() > 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sbq[0].size() + sbq[1].size()), 32'd0);
   endtask

   // Release reset, then check each DUT stays not-ready for exactly DEPTH cycles
   // with no response activity meanwhile.
   task automatic release_and_clear();
      int c0, rc[2];
      rc[0] = -1; rc[1] = -1;
      @(negedge clk);
      rst_n = 1'b1;
      c0 = cyc;
      for (int k = 0; k < 400 && (rc[0] < 0 || rc[1] < 0); k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rc[d] < 0 && rdy[d]) rc[d] = cyc - c0;
            if (vld[d] || err[d]) chk($sformatf("quiet_clear%0d", d), {30'b0, vld[d], err[d]}, 32'd0);
         end
      end
      chk("clear_len0", 32'(rc[0]), 32'd16);
      chk("clear_len1", 32'(rc[1]), 32'd200);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      idle_all();
      // DUT 0 (DEPTH 16, READ_LAT 1)
      add(0, 1, 5,  32'hDEADBEEF, 4'hF, 0, 0);
      add(0, 1, 5,  32'h000000AA, 4'h1, 0, 0);
      add(0, 0, 5,  0, 4'hF, 32'hDEADBEAA, 0);
      add(0, 1, 9,  32'hFFFFFFFF, 4'h0, 0, 0);
      add(0, 0, 9,  0, 4'h0, 32'h00000000, 0);
      add(0, 1, 10, 32'hA1B2C3D4, 4'h6, 0, 0);
      add(0, 0, 10, 0, 4'h0, 32'h00B2C300, 0);
      add(0, 1, 16, 32'h11111111, 4'hF, 0, 1);
      add(0, 0, 16, 0, 4'h0, 32'h00000000, 1);
      add(0, 0, 0,  0, 4'h0, 32'h00000000, 0);
      add(0, 0, 15, 0, 4'h0, 32'h00000000, 0);
      add(0, 0, 255, 0, 4'h0, 32'h00000000, 1);
      add(0, 1, 7,  32'h12345678, 4'hF, 0, 0);
      add(0, 0, 7,  0, 4'h0, 32'h12345678, 0);
      // DUT 1 (DEPTH 200, READ_LAT 2)
      add(1, 1, 1,   32'h00000011, 4'hF, 0, 0);
      add(1, 1, 2,   32'h00000022, 4'hF, 0, 0);
      add(1, 1, 3,   32'h00000033, 4'hF, 0, 0);
      add(1, 0, 3,   0, 4'h0, 32'h00000033, 0);
      add(1, 0, 1,   0, 4'h0, 32'h00000011, 0);
      add(1, 0, 2,   0, 4'h0, 32'h00000022, 0);
      add(1, 1, 250, 32'h55555555, 4'hF, 0, 1);
      add(1, 0, 250, 0, 4'h0, 32'h00000000, 1);
      add(1, 0, 199, 0, 4'h0, 32'h00000000, 0);
      add(1, 1, 199, 32'hCAFEF00D, 4'hF, 0, 0);
      add(1, 0, 199, 0, 4'h0, 32'hCAFEF00D, 0);
      add(1, 1, 2,   32'h1234FF78, 4'h2, 0, 0);
      add(1, 0, 2,   0, 4'h0, 32'h0000FF22, 0);

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd0);
         chk($sformatf("rst_valid%0d", d), 32'(vld[d]), 32'd0);
         chk($sformatf("rst_err%0d", d),   32'(err[d]), 32'd0);
         chk($sformatf("rst_data%0d", d),  rdata[d], 32'd0);
      end
      release_and_clear();
      mon_en = 1'b1;

      // Every word of DUT 0 and the ends of DUT 1 read back as zero
      for (int a = 0; a < 16; a++) begin
         vec_t v;
         v.d = 0; v.w = 0; v.a = 8'(a); v.wdat = 0; v.b = 0; v.exp = 0; v.eerr = 0;
         drive(v);
      end
      begin
         vec_t v;
         v.d = 1; v.w = 0; v.a = 0; v.wdat = 0; v.b = 0; v.exp = 0; v.eerr = 0;
         drive(v);
      end
      drain();

      foreach (vecs[i]) drive(vecs[i]);
      drain();

      // Read data holds between reads
      repeat (3) @(negedge clk);
      chk("hold0", rdata[0], 32'h12345678);
      chk("hold1", rdata[1], 32'h0000FF22);

      // Reset with a read in flight on DUT 1: it must never return
      @(negedge clk);
      req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 8'd3;
      @(negedge clk);
      idle_all();
      mon_en = 1'b0;
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("flush_valid1", 32'(vld[1]), 32'd0);
         chk("flush_ready1", 32'(rdy[1]), 32'd0);
      end
      release_and_clear();
      mon_en = 1'b1;
      begin
         vec_t v;
         v.d = 1; v.w = 0; v.a = 3; v.wdat = 0; v.b = 0; v.exp = 0; v.eerr = 0;
         drive(v);
         v.d = 0; v.a = 7;
         drive(v);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_mem_sync.md
Name: data_mem_sync

Overview:
- Synchronous, parametrised word-addressed data memory for the single-cycle/multi-cycle CPU datapath.
- Replaces the combinational read/write array with a clocked array and a request/ready handshake.
- Adds byte-enable writes, configurable read latency with pipelined reads, out-of-range error reporting and a hardware zero-clear sequence after reset.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 8, word address width.
- DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- READ_LAT, 1, cycles from read acceptance to M_R_Valid; legal values are 1 and 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Mem_Req  input  1  request strobe.
- Mem_Write  input  1  1 = write, 0 = read; sampled with Mem_Req.
- Mem_Addr  input  ADDR_W  word address.
- M_W_Data  input  DATA_W  write data.
- M_BE  input  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- Mem_Ready  output  1  block can accept a request this cycle.
- M_R_Data  output  DATA_W  read data; holds its value until the next read returns.
- M_R_Valid  output  1  one-cycle pulse when M_R_Data is updated.
- Mem_Err  output  1  one-cycle pulse flagging an out-of-range access.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: Mem_Ready=0, M_R_Data=0, M_R_Valid=0, Mem_Err=0.
  - Read pipeline flushed; clear counter=0; FSM in CLEAR.
- FSM states: CLEAR, IDLE.
  - CLEAR: writes 0 to address clr_cnt every cycle, then clr_cnt++. Mem_Ready=0 and Mem_Req is ignored. At clr_cnt==DEPTH-1, the write completes and the FSM moves to IDLE. The clear lasts exactly DEPTH cycles after reset release.
  - IDLE: Mem_Ready=1 every cycle. No return to CLEAR except via reset.
- Acceptance: a request is accepted on the rising edge where Mem_Req && Mem_Ready.
- Write:
  - Committed at the accepting edge.
  - Only bytes with M_BE[i]=1 are updated; M_BE all-zero is a legal no-op.
  - No response pulse unless the access is out of range.
- Read:
  - Array sampled at the accepting edge.
  - M_R_Data and M_R_Valid are updated READ_LAT edges after acceptance. READ_LAT=1 means valid on the cycle after acceptance.
  - Reads are fully pipelined: back-to-back reads give back-to-back M_R_Valid pulses in order.
  - M_BE is ignored on reads.
- Write-then-read: a read accepted the cycle after a write to the same address returns the new data. A single request per cycle makes same-cycle read/write impossible.
- Out of range (Mem_Addr >= DEPTH):
  - Write: ignored, with Mem_Err pulsed on the next cycle.
  - Read: M_R_Valid and Mem_Err pulse together at the normal latency, with M_R_Data=0.
  - When DEPTH==2**ADDR_W, Mem_Err is never asserted.
- Reset mid-operation: in-flight reads are discarded (no M_R_Valid). Array contents are undefined until the CLEAR sequence reruns, which it always does.
- Width rules: no address wrap; addresses are compared against DEPTH at full ADDR_W width.
- Synthesis: array inferred as block RAM with byte-write. The READ_LAT=2 stage is an output register.

Test Plan:
- Reset release with DEPTH=16 -> Mem_Ready stays 0 for exactly 16 cycles then rises; a read of every address returns 0x00000000.
- Write 0xDEADBEEF to addr 5 with M_BE=4'b1111, then write 0x000000AA to addr 5 with M_BE=4'b0001, then read addr 5 -> M_R_Data=0xDEADBEAA, with M_R_Valid one cycle after acceptance (READ_LAT=1).
- READ_LAT=2: write addrs 1, 2, 3 with 0x11, 0x22, 0x33, then issue three back-to-back reads 3, 1, 2 -> three consecutive M_R_Valid pulses starting 2 cycles after the first acceptance, returning data 0x33, 0x11, 0x22.
- DEPTH=200, ADDR_W=8: write addr 250 -> Mem_Err pulses 1 cycle later and a read of addr 250 returns 0 with Mem_Err=1. Then read addr 199 -> Mem_Err=0.
- Write addr 7 = 0x12345678 followed immediately by a read of addr 7 on the next cycle -> returns 0x12345678.
- Issue a read at addr 3, assert rst_n=0 before M_R_Valid -> no M_R_Valid appears. After release, the CLEAR sequence reruns and a read of addr 3 returns 0.
